// File: rtl/mult32x32_fast_driver.sv
`default_nettype none
// ============================================================================
//  Module      : mult32x32_fast_driver
//  Description : Request front-end for mult32x32_fast. Buffers operand pairs
//                in a small FIFO, sequences the multiplier start/busy
//                handshake while holding the head operands stable, and
//                returns each 64-bit product on a valid/ready port in
//                request order.
//  Options     : MULT32X32_DRV_ZERO_BYPASS_EN - when defined, a head entry
//                with a zero operand skips the multiplier and produces 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult32x32_fast_driver #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    // request side
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    // multiplier side
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_busy,
    input  logic [63:0] mul_product,
    // result side
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_product
);

    // DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0]        mem_a_q [DEPTH];
    logic [31:0]        mem_b_q [DEPTH];

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q,  count_d;

    state_t             state_q, state_d;
    logic               mul_start_q;
    logic               out_valid_q;
    logic [63:0]        out_product_q, out_product_d;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_head_zero;

    // ------------------------------------------------------------------
    // FIFO status and head presentation
    // ------------------------------------------------------------------
    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == c_full);
    assign w_push   = in_valid && !w_full;

    assign in_ready = !w_full;
    assign mul_a    = mem_a_q[rd_ptr_q];
    assign mul_b    = mem_b_q[rd_ptr_q];

`ifdef MULT32X32_DRV_ZERO_BYPASS_EN
    // A zero operand makes the product trivially zero; skip the multiplier.
    assign w_head_zero = (mul_a == 32'd0) || (mul_b == 32'd0);
`else
    assign w_head_zero = 1'b0;
`endif

    // Operand storage: written on push only, no reset needed for data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    // Pointer and occupancy update; simultaneous push/pop leaves count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: one multiplier operation outstanding at a time. The head
    // is popped only when its result is captured, so operands stay put
    // from start until busy falls.
    // ------------------------------------------------------------------
    // Next-state, pop and result-capture decisions.
    always_comb begin
        state_d       = state_q;
        w_pop         = 1'b0;
        out_product_d = out_product_q;
        unique case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head_zero) begin
                        state_d       = S_DONE;
                        w_pop         = 1'b1;
                        out_product_d = 64'd0;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!mul_busy) begin
                    state_d       = S_DONE;
                    w_pop         = 1'b1;
                    out_product_d = mul_product;
                end
            end
            S_DONE: begin
                // Hold the result until the consumer takes it; the pop has
                // already happened, so count_q reflects what is left.
                if (out_ready) begin
                    if (w_empty) begin
                        state_d = S_IDLE;
                    end else if (w_head_zero) begin
                        state_d       = S_DONE;
                        w_pop         = 1'b1;
                        out_product_d = 64'd0;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All control state and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            mul_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= 64'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            mul_start_q   <= (state_d == S_START);
            out_valid_q   <= (state_d == S_DONE);
            out_product_q <= out_product_d;
        end
    end

    assign mul_start   = mul_start_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;

endmodule
`default_nettype wire

// File: tb/tb_mult32x32_fast_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult32x32_fast_driver
//  Description : Self-checking bench for mult32x32_fast_driver. Contains a
//                behavioural multiplier with variable busy time and a queue
//                based reference model of expected products.
//  Options     : MULT32X32_DRV_ZERO_BYPASS_EN changes zero-operand checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult32x32_fast_driver;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        m_busy;
    logic [63:0] m_product;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;

    int checks = 0;
    int errors = 0;

    mult32x32_fast_driver #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_busy    (m_busy),
        .mul_product (m_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural multiplier: busy rises on the edge that samples start,
    // stays high lat_cfg cycles (random 1..6 when lat_cfg is 0), product
    // is garbage until busy falls.
    // ------------------------------------------------------------------
    int          lat_cfg = 4;
    int          m_cnt;
    logic [31:0] m_pa;
    logic [31:0] m_pb;

    always @(posedge clk) begin
        if (reset) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            m_product <= 64'd0;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy    <= 1'b0;
                m_product <= 64'(m_pa) * 64'(m_pb);
            end else begin
                m_cnt     <= m_cnt - 1;
                m_product <= {$urandom, $urandom};
            end
        end else if (mul_start) begin
            m_busy    <= 1'b1;
            m_pa      <= mul_a;
            m_pb      <= mul_b;
            m_cnt     <= (lat_cfg == 0) ? int'($urandom_range(6, 1)) : lat_cfg;
            m_product <= {$urandom, $urandom};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and monitor, sampled on the falling edge.
    // ------------------------------------------------------------------
    logic [63:0] exp_q[$];
    logic [63:0] got[$];
    int          n_start = 0;
    logic        prev_busy = 1'b0;
    logic        prev_reset = 1'b1;
    logic        expect_ov = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            expect_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(64'(in_a) * 64'(in_b));
            end
            if (out_valid && out_ready) begin
                chk("result_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    chk("result_order", out_product, exp_q.pop_front());
                end
                got.push_back(out_product);
            end
            if (mul_start) begin
                n_start++;
            end
            chk("start_while_busy", 64'(mul_start && m_busy), 64'd0);
            if (m_busy) begin
                chk("mul_a_stable", 64'(mul_a), 64'(m_pa));
                chk("mul_b_stable", 64'(mul_b), 64'(m_pb));
            end
            if (expect_ov) begin
                chk("ov_one_after_busy", 64'(out_valid), 64'd1);
                expect_ov = 1'b0;
            end
            if (prev_busy && !m_busy && !prev_reset) begin
                chk("ov_low_at_busy_fall", 64'(out_valid), 64'd0);
                expect_ov = 1'b1;
            end
        end
        prev_busy  = m_busy;
        prev_reset = reset;
    end

    // ------------------------------------------------------------------
    // Driver helpers (inputs change 1 time unit after the rising edge).
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && g < 200) begin
            tick();
            g++;
        end
        chk("push_timeout", 64'(g < 200), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int g = 0;
        while (got.size() < n && g < 500) begin
            tick();
            g++;
        end
        chk("result_timeout", 64'(got.size() >= n), 64'd1);
    endtask

    function automatic logic [63:0] got_at(input int i);
        return (got.size() > i) ? got[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    logic [63:0] exp5  [5] = '{64'd2, 64'd6, 64'd12, 64'd20, 64'd30};
    logic [63:0] expw  [5] = '{64'd110, 64'd156, 64'd210, 64'd272, 64'd342};

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int g;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_product", out_product, 64'd0);

        // Single op 3 x 5
        lat_cfg = 4;
        got.delete();
        s = n_start;
        push(32'd3, 32'd5);
        wait_got(1);
        chk("single_product", got_at(0), 64'h0000_0000_0000_000F);
        chk("single_starts", 64'(n_start - s), 64'd1);

        // Max operands
        lat_cfg = 6;
        got.delete();
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_got(1);
        chk("max_product", got_at(0), 64'hFFFF_FFFE_0000_0001);

        // Five pushes with the consumer stalled
        do_reset();
        lat_cfg   = 20;
        out_ready = 1'b0;
        got.delete();
        s = n_start;
        for (int i = 1; i <= 4; i++) begin
            push(32'(i), 32'(i + 1));
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        push(32'd5, 32'd6);
        repeat (5) tick();
        chk("stalled_one_start", 64'(n_start - s), 64'd1);
        chk("stalled_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        wait_got(5);
        for (int i = 0; i < 5; i++) begin
            chk("stalled_order", got_at(i), exp5[i]);
        end

        // Reset during WAIT with three entries queued
        lat_cfg = 10;
        push(32'd1, 32'd2);
        push(32'd3, 32'd4);
        push(32'd5, 32'd6);
        g = 0;
        while (!m_busy && g < 50) begin
            tick();
            g++;
        end
        chk("reset_reach_wait", 64'(m_busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_mul_start", 64'(mul_start), 64'd0);
        s = n_start;
        repeat (5) tick();
        chk("midrst_no_start", 64'(n_start - s), 64'd0);
        got.delete();
        lat_cfg = 3;
        push(32'd7, 32'd9);
        wait_got(1);
        chk("post_reset_63", got_at(0), 64'd63);

        // Zero operand
        got.delete();
        s = n_start;
        push(32'd0, 32'd7);
        wait_got(1);
        chk("zero_product", got_at(0), 64'd0);
`ifdef MULT32X32_DRV_ZERO_BYPASS_EN
        chk("zero_no_start", 64'(n_start - s), 64'd0);
`else
        chk("zero_one_start", 64'(n_start - s), 64'd1);
`endif

        // Simultaneous push and pop at occupancy 3
        do_reset();
        lat_cfg   = 12;
        out_ready = 1'b0;
        got.delete();
        push(32'd10, 32'd11);
        push(32'd12, 32'd13);
        push(32'd14, 32'd15);
        g = 0;
        while (!m_busy && g < 50) begin
            tick();
            g++;
        end
        g = 0;
        while (m_busy && g < 50) begin
            tick();
            g++;
        end
        chk("pp_busy_fell", 64'(m_busy), 64'd0);
        chk("pp_ready_before", 64'(in_ready), 64'd1);
        push(32'd16, 32'd17);
        chk("pp_ready_after", 64'(in_ready), 64'd1);
        push(32'd18, 32'd19);
        chk("pp_full_after", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        wait_got(5);
        for (int i = 0; i < 5; i++) begin
            chk("pp_order", got_at(i), expw[i]);
        end

        // Randomized traffic against the queue model
        do_reset();
        lat_cfg = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 2) == 0;
            in_a      = (($urandom % 8) == 0) ? 32'd0 : $urandom;
            in_b      = (($urandom % 8) == 0) ? 32'd0 : $urandom;
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 2000) begin
            tick();
            g++;
        end
        chk("random_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
